// File: rtl/demux1x4_reg.sv
// demux1x4_reg: registered 1-to-4 demultiplexer with valid/ready handshakes.
// Each destination channel owns a one-entry holding register, so a stalled
// consumer only blocks words addressed to its own channel.
module demux1x4_reg #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       in_sel,
   input  logic [WIDTH-1:0] in_data,
   output logic [3:0]       out_valid,
   input  logic [3:0]       out_ready,
   output logic [WIDTH-1:0] out_data0,
   output logic [WIDTH-1:0] out_data1,
   output logic [WIDTH-1:0] out_data2,
   output logic [WIDTH-1:0] out_data3,
   output logic             busy
);

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } chan_state_t;

   chan_state_t      state  [4];
   logic [WIDTH-1:0] data_q [4];
   logic             acc;
   logic [3:0]       ld;
   logic [3:0]       drn;

   // Handshake decode: readiness depends only on the addressed channel's
   // state and its consumer, never on in_valid or in_data.
   always_comb begin
      out_valid = '0;
      ld        = '0;
      drn       = '0;
      for (int unsigned k = 0; k < 4; k++) begin
         out_valid[k] = (state[k] == FULL);
      end
      in_ready = ~out_valid[in_sel] | out_ready[in_sel];
      acc      = in_valid & in_ready;
      for (int unsigned k = 0; k < 4; k++) begin
         ld[k]  = acc & (in_sel == 2'(k));
         drn[k] = out_valid[k] & out_ready[k];
      end
      busy = |out_valid;
   end

   // Per-channel EMPTY/FULL state and holding register; data only moves on a load.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned k = 0; k < 4; k++) begin
            state[k]  <= EMPTY;
            data_q[k] <= '0;
         end
      end else begin
         for (int unsigned k = 0; k < 4; k++) begin
            unique case (state[k])
               EMPTY: if (ld[k]) state[k] <= FULL;
               FULL:  if (drn[k] && !ld[k]) state[k] <= EMPTY;
               default: state[k] <= EMPTY;
            endcase
            if (ld[k]) begin
               data_q[k] <= in_data;
            end
         end
      end
   end

   assign out_data0 = data_q[0];
   assign out_data1 = data_q[1];
   assign out_data2 = data_q[2];
   assign out_data3 = data_q[3];

endmodule

// File: tb/tb_demux1x4_reg.sv
// tb_demux1x4_reg: directed vector table, reset/corner sequences and a
// scoreboard-checked random soak for demux1x4_reg.
module tb_demux1x4_reg;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [1:0]  in_sel;
   logic [31:0] in_data;
   logic [3:0]  out_valid;
   logic [3:0]  out_ready;
   logic [31:0] out_data0, out_data1, out_data2, out_data3;
   logic        busy;

   int tests = 0;
   int fails = 0;

   demux1x4_reg #(.WIDTH(32)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_sel   (in_sel),
      .in_data  (in_data),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_data0(out_data0),
      .out_data1(out_data1),
      .out_data2(out_data2),
      .out_data3(out_data3),
      .busy     (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        iv;
      logic [1:0]  sel;
      logic [31:0] din;
      logic [3:0]  ordy;
      logic        rdy;   // expected in_ready before the edge
      logic [3:0]  vld;   // expected out_valid after the edge
      logic [1:0]  ch;    // channel whose data is checked after the edge
      logic [31:0] dat;   // expected out_data of that channel
   } vec_t;

   vec_t vecs [19];

   function automatic logic [31:0] get_data(input int k);
      case (k)
         0: return out_data0;
         1: return out_data1;
         2: return out_data2;
         default: return out_data3;
      endcase
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   logic [31:0] sbq [4][$];
   logic [31:0] held [4];
   logic [3:0]  hold_chk;
   logic [3:0]  exp_v;
   logic        exp_r;
   logic        pend;
   logic [1:0]  p_sel;
   logic [31:0] p_dat;

   initial begin
      // basic route, all consumers ready
      vecs[0]  = '{1'b1, 2'd0, 32'hA000_0000, 4'b1111, 1'b1, 4'b0001, 2'd0, 32'hA000_0000};
      vecs[1]  = '{1'b1, 2'd1, 32'hA000_0001, 4'b1111, 1'b1, 4'b0010, 2'd1, 32'hA000_0001};
      vecs[2]  = '{1'b1, 2'd2, 32'hA000_0002, 4'b1111, 1'b1, 4'b0100, 2'd2, 32'hA000_0002};
      vecs[3]  = '{1'b1, 2'd3, 32'hA000_0003, 4'b1111, 1'b1, 4'b1000, 2'd3, 32'hA000_0003};
      vecs[4]  = '{1'b0, 2'd0, 32'h0000_0000, 4'b1111, 1'b1, 4'b0000, 2'd3, 32'hA000_0003};
      // back-pressure isolation on channel 0
      vecs[5]  = '{1'b1, 2'd0, 32'h0000_0011, 4'b1110, 1'b1, 4'b0001, 2'd0, 32'h0000_0011};
      vecs[6]  = '{1'b1, 2'd0, 32'h0000_0022, 4'b1110, 1'b0, 4'b0001, 2'd0, 32'h0000_0011};
      vecs[7]  = '{1'b1, 2'd0, 32'h0000_0022, 4'b1110, 1'b0, 4'b0001, 2'd0, 32'h0000_0011};
      vecs[8]  = '{1'b1, 2'd2, 32'h0000_0033, 4'b1110, 1'b1, 4'b0101, 2'd2, 32'h0000_0033};
      vecs[9]  = '{1'b0, 2'd0, 32'h0000_0000, 4'b1110, 1'b0, 4'b0001, 2'd0, 32'h0000_0011};
      // simultaneous drain and refill on channel 1
      vecs[10] = '{1'b1, 2'd1, 32'h0000_0055, 4'b0000, 1'b1, 4'b0011, 2'd1, 32'h0000_0055};
      vecs[11] = '{1'b1, 2'd1, 32'h0000_0066, 4'b0010, 1'b1, 4'b0011, 2'd1, 32'h0000_0066};
      vecs[12] = '{1'b0, 2'd0, 32'h0000_0000, 4'b0011, 1'b1, 4'b0000, 2'd0, 32'h0000_0011};
      // fill all four, then multi-drain
      vecs[13] = '{1'b1, 2'd0, 32'h0000_00B0, 4'b0000, 1'b1, 4'b0001, 2'd0, 32'h0000_00B0};
      vecs[14] = '{1'b1, 2'd1, 32'h0000_00B1, 4'b0000, 1'b1, 4'b0011, 2'd1, 32'h0000_00B1};
      vecs[15] = '{1'b1, 2'd2, 32'h0000_00B2, 4'b0000, 1'b1, 4'b0111, 2'd2, 32'h0000_00B2};
      vecs[16] = '{1'b1, 2'd3, 32'h0000_00B3, 4'b0000, 1'b1, 4'b1111, 2'd3, 32'h0000_00B3};
      vecs[17] = '{1'b1, 2'd1, 32'h0000_00CC, 4'b0000, 1'b0, 4'b1111, 2'd1, 32'h0000_00B1};
      vecs[18] = '{1'b0, 2'd0, 32'h0000_0000, 4'b1111, 1'b1, 4'b0000, 2'd2, 32'h0000_00B2};

      rst_n = 1'b0; in_valid = 1'b0; in_sel = 2'd0; in_data = '0; out_ready = '0;
      repeat (2) @(posedge clk);
      #1;
      check("reset out_valid", 32'(out_valid), 32'h0);
      check("reset busy", 32'(busy), 32'h0);
      check("reset in_ready", 32'(in_ready), 32'h1);
      rst_n = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 19; i++) begin
         in_valid = vecs[i].iv; in_sel = vecs[i].sel;
         in_data = vecs[i].din; out_ready = vecs[i].ordy;
         #1;
         check($sformatf("vec%0d in_ready", i), 32'(in_ready), 32'(vecs[i].rdy));
         @(posedge clk); #1;
         check($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'(vecs[i].vld));
         check($sformatf("vec%0d busy", i), 32'(busy), 32'(|vecs[i].vld));
         check($sformatf("vec%0d out_data%0d", i, vecs[i].ch), get_data(int'(vecs[i].ch)), vecs[i].dat);
      end

      // async reset with channels 1 and 3 full
      out_ready = 4'b0000; in_valid = 1'b1;
      in_sel = 2'd1; in_data = 32'h0000_0077;
      @(posedge clk); #1;
      in_sel = 2'd3; in_data = 32'h0000_0099;
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("pre-reset out_valid", 32'(out_valid), 32'hA);
      check("pre-reset out_data3", out_data3, 32'h0000_0099);
      #2 rst_n = 1'b0;
      #1;
      check("async reset out_valid", 32'(out_valid), 32'h0);
      check("async reset busy", 32'(busy), 32'h0);
      for (int k = 0; k < 4; k++)
         check($sformatf("async reset out_data%0d", k), get_data(k), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int s = 0; s < 4; s++) begin
         in_sel = 2'(s);
         #1;
         check($sformatf("post-reset in_ready sel%0d", s), 32'(in_ready), 32'h1);
      end
      @(posedge clk); #1;

      // random soak against per-channel scoreboard queues
      pend = 1'b0; p_sel = '0; p_dat = '0;
      for (int c = 0; c < 10000; c++) begin
         if (!pend && ($urandom_range(0, 1) == 1)) begin
            pend  = 1'b1;
            p_sel = 2'($urandom_range(0, 3));
            p_dat = 32'h5000_0000 + 32'(c);
         end
         in_valid  = pend;
         in_sel    = pend ? p_sel : 2'($urandom_range(0, 3));
         in_data   = pend ? p_dat : $urandom;
         out_ready = 4'($urandom_range(0, 15));
         #1;
         for (int k = 0; k < 4; k++) exp_v[k] = (sbq[k].size() != 0);
         exp_r = ~exp_v[in_sel] | out_ready[in_sel];
         check("soak in_ready", 32'(in_ready), 32'(exp_r));
         check("soak out_valid", 32'(out_valid), 32'(exp_v));
         hold_chk = '0;
         for (int k = 0; k < 4; k++) begin
            if (exp_v[k] && out_ready[k]) begin
               check($sformatf("soak drain ch%0d", k), get_data(k), sbq[k][0]);
               void'(sbq[k].pop_front());
            end else if (exp_v[k]) begin
               held[k] = get_data(k);
               hold_chk[k] = 1'b1;
            end
         end
         if (in_valid && exp_r) begin
            sbq[in_sel].push_back(in_data);
            pend = 1'b0;
         end
         @(posedge clk); #1;
         for (int k = 0; k < 4; k++)
            if (hold_chk[k]) check($sformatf("soak hold ch%0d", k), get_data(k), held[k]);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
